operand_bus_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one 32-bit operand path into the ALU.
- Drives the select line of the shared 32-bit 2:1 operand mux and grants ownership to one requester at a time.
- Registers the selected operand with a valid strobe and a source tag for the downstream ALU stage.
- Bounds continuous ownership to MAX_HOLD cycles so neither requester starves.

---
 rtl/operand_bus_arbiter.sv | 112 +++++++++++
 tb/tb_operand_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_bus_arbiter.sv
// Two-requester round-robin arbiter driving a shared operand mux; registers the selected operand, valid and source tag.
// Grant one cycle after a request in IDLE, operand one cycle after a transfer edge; a grant is held at most MAX_HOLD cycles under contention.
module operand_bus_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    output logic             o_src
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic [HW-1:0]     r_hold;
    logic [HW-1:0]     w_hold_nxt;
    logic [WIDTH-1:0]  r_o;
    logic              r_o_valid;
    logic              r_o_src;
    logic              w_owner;
    logic              w_mine;
    logic              w_other;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_din;

    assign gnt0    = (r_state == G0);
    assign gnt1    = (r_state == G1);
    assign sel     = gnt1;
    assign o       = r_o;
    assign o_valid = r_o_valid;
    assign o_src   = r_o_src;

    // Shared operand mux, steered by the registered select
    assign w_din = sel ? I1 : I0;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        w_owner     = (r_state == G1);
        w_mine      = w_owner ? req1 : req0;
        w_other     = w_owner ? req0 : req1;
        w_xfer      = (r_state != IDLE) && w_mine;
        case (r_state)
            IDLE: begin
                if (req0 && req1)
                    w_state_nxt = r_last ? G0 : G1;
                else if (req0)
                    w_state_nxt = G0;
                else if (req1)
                    w_state_nxt = G1;
            end
            G0, G1: begin
                if (!w_mine) begin
                    // Owner released: hand straight over, or fall back to idle
                    w_hold_nxt  = '0;
                    w_last_nxt  = w_owner;
                    w_state_nxt = w_other ? (w_owner ? G0 : G1) : IDLE;
                end else if (r_hold == HOLD_LAST) begin
                    w_hold_nxt = '0;
                    if (w_other) begin
                        w_state_nxt = w_owner ? G0 : G1;
                        w_last_nxt  = w_owner;
                    end
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_hold    <= '0;
            r_o       <= '0;
            r_o_valid <= 1'b0;
            r_o_src   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
            r_o_valid <= w_xfer;
            if (w_xfer) begin
                r_o     <= w_din;
                r_o_src <= w_owner;
            end
        end
    end

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD 8 and 1) share stimulus; a reference model predicts each edge.
module tb_operand_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] I0, I1;

    logic        a_gnt0, a_gnt1, a_sel, a_v, a_src;
    logic [31:0] a_o;
    logic        b_gnt0, b_gnt1, b_sel, b_v, b_src;
    logic [31:0] b_o;

    operand_bus_arbiter #(.WIDTH(32), .MAX_HOLD(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .I0(I0), .I1(I1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .sel(a_sel), .o(a_o), .o_valid(a_v), .o_src(a_src)
    );

    operand_bus_arbiter #(.WIDTH(32), .MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .I0(I0), .I1(I1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .sel(b_sel), .o(b_o), .o_valid(b_v), .o_src(b_src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        g0, g1, sl, v, src;
        logic [31:0] o;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   seen_deadbeef = 0;

    // Reference model state: st 0=idle 1=owner0 2=owner1
    int          m_st[2];
    int          m_hold[2];
    logic        m_last[2];
    logic [31:0] m_o[2];
    logic        m_v[2];
    logic        m_src[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input int mh);
        int   n;
        logic mine, oth;
        if (!rst_n) begin
            m_st[k] = 0; m_last[k] = 1'b1; m_hold[k] = 0;
            m_o[k] = '0; m_v[k] = 1'b0; m_src[k] = 1'b0;
            return;
        end
        m_v[k] = 1'b0;
        if (m_st[k] == 0) begin
            if (req0 && req1) m_st[k] = m_last[k] ? 1 : 2;
            else if (req0)    m_st[k] = 1;
            else if (req1)    m_st[k] = 2;
        end else begin
            n    = m_st[k] - 1;
            mine = (n == 1) ? req1 : req0;
            oth  = (n == 1) ? req0 : req1;
            if (!mine) begin
                m_hold[k] = 0;
                m_last[k] = n[0];
                m_st[k]   = oth ? 3 - m_st[k] : 0;
            end else begin
                m_o[k]   = (n == 1) ? I1 : I0;
                m_v[k]   = 1'b1;
                m_src[k] = n[0];
                if (m_hold[k] == mh - 1) begin
                    m_hold[k] = 0;
                    if (oth) begin
                        m_st[k]   = 3 - m_st[k];
                        m_last[k] = n[0];
                    end
                end else begin
                    m_hold[k] = m_hold[k] + 1;
                end
            end
        end
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t e;
        e.g0  = (m_st[k] == 1);
        e.g1  = (m_st[k] == 2);
        e.sl  = (m_st[k] == 2);
        e.v   = m_v[k];
        e.src = m_src[k];
        e.o   = m_o[k];
        return e;
    endfunction

    // One clock: predict at the falling edge, compare 1 time unit after the rising edge
    task automatic tick();
        obs_t e, g;
        @(negedge clk);
        model_step(0, 8);
        model_step(1, 1);
        exp_q.push_back(model_obs(0));
        exp_q.push_back(model_obs(1));
        @(posedge clk);
        #1;
        if ((a_v && a_o == 32'hDEADBEEF) || (b_v && b_o == 32'hDEADBEEF)) seen_deadbeef = 1;
        e = exp_q.pop_front();
        g = '{a_gnt0, a_gnt1, a_sel, a_v, a_src, a_o};
        check("dut8.ctl", 64'(g[36:32]), 64'(e[36:32]));
        check("dut8.o", 64'(g.o), 64'(e.o));
        e = exp_q.pop_front();
        g = '{b_gnt0, b_gnt1, b_sel, b_v, b_src, b_o};
        check("dut1.ctl", 64'(g[36:32]), 64'(e[36:32]));
        check("dut1.o", 64'(g.o), 64'(e.o));
    endtask

    initial begin
        int n_g0, n_v, n_tog, n_g1;
        logic prev;
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; I0 = 32'h0; I1 = 32'h0;
        m_st = '{0, 0}; m_hold = '{0, 0}; m_last = '{1'b1, 1'b1};
        m_o = '{32'h0, 32'h0}; m_v = '{1'b0, 1'b0}; m_src = '{1'b0, 1'b0};

        // Reset held with both requests high
        tick(); tick();
        check("rst.gnt", 64'({a_gnt0, a_gnt1}), 64'(0));
        check("rst.o", 64'(a_o), 64'(0));
        check("rst.valid", 64'(a_v), 64'(0));
        rst_n = 1'b1;
        tick();
        check("rst.first_tie_gnt0", 64'(a_gnt0), 64'(1));
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();

        // Single requester, operands presented on granted cycles
        req0 = 1'b1; I0 = 32'h0;
        tick();
        I0 = 32'h11; tick();
        I0 = 32'h22; tick();
        I0 = 32'h33; tick();
        check("single.o_last", 64'(a_o), 64'h33);
        req0 = 1'b0; tick();
        check("single.idle", 64'(a_gnt0), 64'(0));
        tick();

        // Continuous contention
        req0 = 1'b1; req1 = 1'b1;
        tick();
        n_g0 = 0; n_v = 0; n_tog = 0; prev = b_gnt0;
        for (int i = 0; i < 32; i++) begin
            I0 = $urandom & 32'h00FF_FFFF; I1 = $urandom & 32'h00FF_FFFF;
            tick();
            if (a_gnt0) n_g0++;
            if (a_v) n_v++;
            if (b_gnt0 != prev) n_tog++;
            prev = b_gnt0;
        end
        check("contend.gnt0_cycles", 64'(n_g0), 64'(16));
        check("contend.transfers", 64'(n_v), 64'(32));
        check("contend.mh1_toggles", 64'(n_tog), 64'(32));
        req0 = 1'b0; req1 = 1'b0; tick(); tick();

        // Early release of grant 0 while requester 1 waits
        req0 = 1'b1; tick();
        req1 = 1'b1; I0 = 32'h1234; tick();
        I0 = 32'h5678; tick();
        req0 = 1'b0; I1 = 32'h9ABC; tick();
        check("early.gnt1", 64'(a_gnt1), 64'(1));
        tick();
        check("early.src", 64'({a_v, a_src}), 64'(3));
        req1 = 1'b0; tick(); tick();

        // Single requester past the hold limit keeps its grant
        req1 = 1'b1; n_g1 = 0;
        for (int i = 0; i < 20; i++) begin
            I1 = $urandom & 32'h00FF_FFFF;
            tick();
            if (a_gnt1) n_g1++;
        end
        check("hold.gnt1_cycles", 64'(n_g1), 64'(20));

        // Reset in the middle of a grant
        I1 = 32'hDEADBEEF; rst_n = 1'b0;
        tick();
        check("midrst.o", 64'(a_o), 64'(0));
        check("midrst.gnt1", 64'(a_gnt1), 64'(0));
        rst_n = 1'b1; req1 = 1'b0; I1 = 32'h0;
        tick(); tick();

        // Random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            req0  = $urandom_range(0, 3) != 0;
            req1  = $urandom_range(0, 2) != 0;
            I0    = $urandom & 32'h00FF_FFFF;
            I1    = $urandom & 32'h00FF_FFFF;
            rst_n = $urandom_range(0, 40) != 0;
            tick();
        end
        check("deadbeef_never_out", 64'(seen_deadbeef), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
